// File: rtl/otter_fetch_queue_pkg.sv
// rtl/otter_fetch_queue_pkg.sv - shared types and constants for the OTTER fetch front end
//
// Purpose: shared types and constants for the fetch front end.
//   fetch_entry_t      : {pc, ir} pair handed to decode (default 32-bit datapath)
//   FETCH_RESET_VECTOR : PC fetched first after reset
//   FETCH_XLEN         : datapath width that fetch_entry_t is sized for
package otter_fetch_queue_pkg;

  localparam int FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] FETCH_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/otter_fetch_queue_fifo.sv
// rtl/otter_fetch_queue_fifo.sv - circular prefetch queue holding fetched {pc, ir} entries
//
// Purpose: DEPTH-entry circular queue holding fetched instructions.
// Ports:
//   CLK, RESET      : clock, asynchronous active-high reset
//   clear           : drop every entry (redirect); wins over push/pop
//   push, push_data : write one entry at the tail
//   pop             : retire the head entry (caller guarantees non-empty)
//   head            : head entry, all zero while empty
//   empty, count    : queue status
module fetch_fifo
  import otter_fetch_queue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         clear,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  output entry_t                       head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge CLK) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/otter_fetch_queue.sv
// rtl/otter_fetch_queue.sv - OTTER instruction-fetch front end with prefetch queue
//
// Purpose: PC generator, pipelined instruction-memory port and prefetch queue
// feeding {pc, ir} pairs to decode; a redirect flushes everything in one cycle.
// Ports:
//   CLK, RESET              : clock, asynchronous active-high reset
//   imem_rden, imem_addr    : instruction-memory read request (word address)
//   imem_rdata              : read data, valid the cycle after imem_rden
//   redirect, redirect_pc   : taken branch/jump from EX and its target
//   de_valid, de_ready      : handshake with decode
//   de_pc, de_ir            : head entry (zero while empty)
//   occupancy               : number of queued entries
module otter_fetch_queue
  import otter_fetch_queue_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 4,
  parameter int              IMEM_AW      = 14,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(FETCH_RESET_VECTOR)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  output logic                        imem_rden,
  output logic [IMEM_AW-1:0]          imem_addr,
  input  logic [XLEN-1:0]             imem_rdata,
  input  logic                        redirect,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        de_valid,
  input  logic                        de_ready,
  output logic [XLEN-1:0]             de_pc,
  output logic [XLEN-1:0]             de_ir,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } entry_t;

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [XLEN-1:0] issue_pc;
  logic            issue;
  logic            pop;
  logic            push;
  logic [CW:0]     credit;
  logic [CW-1:0]   count;
  logic            empty;
  entry_t          head;
  entry_t          push_data;
  logic            unused_pc_lsbs;

  // Target byte offset within the word is meaningless for fetch.
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign pop  = ~empty & de_ready & ~redirect;
  assign push = inflight & ~redirect;

  // Slots that will be committed once the in-flight read lands, net of the
  // entry leaving this cycle; counting the pop lets a freed slot be refilled
  // in the same cycle without a bubble.
  assign credit = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

  assign issue    = ~RESET & (redirect | (credit < (CW+1)'(DEPTH)));
  assign issue_pc = redirect ? {redirect_pc[XLEN-1:2], 2'b00} : fpc;

  assign imem_rden = issue;
  assign imem_addr = issue_pc[IMEM_AW+1:2];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fpc         <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fpc         <= issue_pc + XLEN'(4);
        inflight_pc <= issue_pc;
      end
    end
  end

  assign push_data = '{pc: inflight_pc, ir: imem_rdata};

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .clear     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .count     (count)
  );

  assign de_valid  = ~empty;
  assign de_pc     = head.pc;
  assign de_ir     = head.ir;
  assign occupancy = count;

endmodule
